// File: rtl/peripheral_dbg_pu_riscv_pkg.sv
// Shared types for the debug-bridge burst sequencer: FSM states, beat sizes,
// and the shift that moves right-aligned write data to the BIU's MSB lanes.
package peripheral_dbg_pu_riscv_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_STROBE,
      ST_WAIT,
      ST_PUSH,
      ST_DONE
   } burst_state_e;

   localparam logic [3:0] WSIZE_1 = 4'd1;
   localparam logic [3:0] WSIZE_2 = 4'd2;
   localparam logic [3:0] WSIZE_4 = 4'd4;
   localparam logic [3:0] WSIZE_8 = 4'd8;

   // A beat as wide as (or wider than) the bus needs no shift.
   function automatic int unsigned wdata_shift(int unsigned dw, logic [3:0] size);
      int unsigned bits;
      case (size)
         WSIZE_1: bits = 8;
         WSIZE_2: bits = 16;
         WSIZE_4: bits = 32;
         WSIZE_8: bits = 64;
         default: bits = dw;
      endcase
      return (bits >= dw) ? 0 : dw - bits;
   endfunction

endpackage

// File: rtl/peripheral_dbg_pu_riscv_bb_burst_if.sv
// Command, beat-stream and BIU signals of the burst sequencer.
// slave = the sequencer, master = the debug bus module plus the BIU.
interface peripheral_dbg_pu_riscv_bb_burst_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
);
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic                  cmd_write;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [3:0]            cmd_word_size;
   logic [CNT_WIDTH-1:0]  cmd_count;
   logic                  abort;
   logic                  wr_valid;
   logic                  wr_ready;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  rd_valid;
   logic                  rd_ready;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  busy;
   logic                  done;
   logic                  err;
   logic                  biu_strb;
   logic                  biu_rw;
   logic [ADDR_WIDTH-1:0] biu_addr;
   logic [DATA_WIDTH-1:0] biu_di;
   logic [3:0]            biu_word_size;
   logic [DATA_WIDTH-1:0] biu_do;
   logic                  biu_rdy;
   logic                  biu_err;

   modport slave (
      input  cmd_valid, cmd_write, cmd_addr, cmd_word_size, cmd_count, abort,
             wr_valid, wr_data, rd_ready, biu_do, biu_rdy, biu_err,
      output cmd_ready, wr_ready, rd_valid, rd_data, busy, done, err,
             biu_strb, biu_rw, biu_addr, biu_di, biu_word_size
   );

   modport master (
      output cmd_valid, cmd_write, cmd_addr, cmd_word_size, cmd_count, abort,
             wr_valid, wr_data, rd_ready, biu_do, biu_rdy, biu_err,
      input  cmd_ready, wr_ready, rd_valid, rd_data, busy, done, err,
             biu_strb, biu_rw, biu_addr, biu_di, biu_word_size
   );
endinterface

// File: rtl/peripheral_dbg_pu_riscv_bb_burst.sv
// Burst sequencer: expands one debug-bus command into `count` single BIU
// accesses, streaming write beats in and read beats out.
//
// state  | meaning
// IDLE   | cmd_ready high, waiting for a command
// FETCH  | wr_ready high, waiting for the next write beat
// STROBE | biu_strb high until the BIU takes it
// WAIT   | access outstanding, waiting for biu_rdy
// PUSH   | read beat held on rd_data until rd_ready
// DONE   | one-cycle done pulse, then back to IDLE
module peripheral_dbg_pu_riscv_bb_burst
   import peripheral_dbg_pu_riscv_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic biu_clk,
   input  logic biu_rstn,
   peripheral_dbg_pu_riscv_bb_burst_if.slave bus
);

   burst_state_e          state_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [3:0]            size_q;
   logic                  rw_q;
   logic [CNT_WIDTH-1:0]  cnt_q;
   logic [DATA_WIDTH-1:0] di_q;
   logic [DATA_WIDTH-1:0] rd_data_q;
   logic                  rd_valid_q;
   logic                  wr_ready_q;
   logic                  cmd_ready_q;
   logic                  strb_q;
   logic                  busy_q;
   logic                  done_q;
   logic                  err_q;
   logic                  abort_q;

   logic [ADDR_WIDTH-1:0] addr_d;
   logic [CNT_WIDTH-1:0]  cnt_d;
   logic [DATA_WIDTH-1:0] di_d;

   assign addr_d = addr_q + ADDR_WIDTH'(size_q);
   assign cnt_d  = cnt_q - CNT_WIDTH'(1);
   assign di_d   = bus.wr_data << wdata_shift(DATA_WIDTH, size_q);

   always_ff @(posedge biu_clk or negedge biu_rstn) begin
      if (!biu_rstn) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         size_q      <= '0;
         rw_q        <= 1'b0;
         cnt_q       <= '0;
         di_q        <= '0;
         rd_data_q   <= '0;
         rd_valid_q  <= 1'b0;
         wr_ready_q  <= 1'b0;
         cmd_ready_q <= 1'b1;
         strb_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         abort_q     <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.cmd_valid && cmd_ready_q) begin
                  addr_q      <= bus.cmd_addr;
                  size_q      <= bus.cmd_word_size;
                  rw_q        <= ~bus.cmd_write;
                  cnt_q       <= bus.cmd_count;
                  err_q       <= 1'b0;
                  abort_q     <= 1'b0;
                  cmd_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  if (bus.cmd_count == '0) begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                  end else if (bus.cmd_write) begin
                     state_q    <= ST_FETCH;
                     wr_ready_q <= 1'b1;
                  end else begin
                     state_q <= ST_STROBE;
                     strb_q  <= 1'b1;
                  end
               end
            end
            ST_FETCH: begin
               if (bus.abort) begin
                  wr_ready_q <= 1'b0;
                  state_q    <= ST_DONE;
                  done_q     <= 1'b1;
               end else if (bus.wr_valid) begin
                  di_q       <= di_d;
                  wr_ready_q <= 1'b0;
                  strb_q     <= 1'b1;
                  state_q    <= ST_STROBE;
               end
            end
            ST_STROBE: begin
               // If the BIU takes the strobe on the abort edge the access is
               // already in flight, so it must still be waited out.
               if (strb_q && bus.biu_rdy) begin
                  strb_q  <= 1'b0;
                  abort_q <= bus.abort;
                  state_q <= ST_WAIT;
               end else if (bus.abort) begin
                  strb_q  <= 1'b0;
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
               end
            end
            ST_WAIT: begin
               if (bus.biu_rdy) begin
                  err_q  <= err_q | bus.biu_err;
                  addr_q <= addr_d;
                  cnt_q  <= cnt_d;
                  if (abort_q || bus.abort) begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                  end else if (rw_q) begin
                     rd_data_q  <= bus.biu_do;
                     rd_valid_q <= 1'b1;
                     state_q    <= ST_PUSH;
                  end else if (cnt_d == '0) begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     wr_ready_q <= 1'b1;
                     state_q    <= ST_FETCH;
                  end
               end else if (bus.abort) begin
                  abort_q <= 1'b1;
               end
            end
            ST_PUSH: begin
               if (bus.abort) begin
                  rd_valid_q <= 1'b0;
                  state_q    <= ST_DONE;
                  done_q     <= 1'b1;
               end else if (bus.rd_ready) begin
                  rd_valid_q <= 1'b0;
                  if (cnt_q == '0) begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     strb_q  <= 1'b1;
                     state_q <= ST_STROBE;
                  end
               end
            end
            ST_DONE: begin
               done_q      <= 1'b0;
               busy_q      <= 1'b0;
               cmd_ready_q <= 1'b1;
               abort_q     <= 1'b0;
               state_q     <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.cmd_ready     = cmd_ready_q;
   assign bus.wr_ready      = wr_ready_q;
   assign bus.rd_valid      = rd_valid_q;
   assign bus.rd_data       = rd_data_q;
   assign bus.busy          = busy_q;
   assign bus.done          = done_q;
   assign bus.err           = err_q;
   assign bus.biu_strb      = strb_q;
   assign bus.biu_rw        = rw_q;
   assign bus.biu_addr      = addr_q;
   assign bus.biu_di        = di_q;
   assign bus.biu_word_size = size_q;

endmodule
